led_shifter: RTL

Frame refresh engine directly downstream of the framebuffer. It walks every channel of the framebuffer through its registered read port and serialises each c_bpc-bit value MSB-first onto the daisy-chained LED driver boards. It then pulses the driver latch and waits a programmable dwell time before starting the next frame. The dwell time comes from the framebuffer's time output.

---
 rtl/lamp_pkg.sv | 37 +++
 rtl/led_serializer.sv | 78 +++++++
 rtl/led_shifter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/lamp_pkg.sv
// lamp_pkg
// Shared definitions for the lamp display pipeline (framebuffer and
// led_shifter). Holds the chain geometry defaults, the refresh engine state
// enumeration and the width helpers used to size ports and counters, so the
// framebuffer and the refresh engine always agree on the dwell field width.
package lamp_pkg;

  // Default chain geometry: boards in the daisy chain, channels per driver
  // board and bits per channel.
  localparam int c_ledboards_default = 30;
  localparam int c_ch_per_board      = 32;
  localparam int c_bpc_default       = 12;
  localparam int c_max_time_default  = 480;
  localparam int c_tick_div_default  = 1000;

  // Refresh engine states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    DWELL,
    FETCH0,
    FETCH1,
    SHIFT,
    GAP,
    LATCH
  } led_state_t;

  // Width of the dwell field carried from the framebuffer time output.
  function automatic int time_width(input int max_time);
    return $clog2(max_time);
  endfunction

  // Counter width for a modulus of n; a modulus of 1 still needs a 1-bit
  // register so the counter never collapses to zero width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_serializer.sv
// led_serializer
// Serialises one c_bpc-bit channel value MSB-first onto the driver serial
// bus. Each bit takes two cycles: data is presented with sclk low, then sclk
// goes high with data held, giving one cycle of setup and one of hold.
// While idle both sclk and sdata sit low.
//
// Ports:
//   i_clk   in   rising-edge clock
//   i_rst   in   synchronous active-high reset
//   load    in   capture data and start shifting on the next cycle
//   data    in   c_bpc-bit channel value to serialise
//   done    out  high during the final cycle of the last bit
//   sclk    out  registered driver serial clock
//   sdata   out  registered driver serial data
module led_serializer
  import lamp_pkg::*;
#(
  parameter int c_bpc = c_bpc_default
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             load,
  input  logic [c_bpc-1:0] data,
  output logic             done,
  output logic             sclk,
  output logic             sdata
);

  localparam int c_bit_w = cnt_width(c_bpc);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_bpc - 1);

  logic [c_bpc-1:0]   shreg;
  logic [c_bit_w-1:0] bit_cnt;
  logic               phase;
  logic               active;

  // Shift engine. The MSB is driven straight from the load data so the first
  // bit is already on sdata in the first shift cycle; every later bit comes
  // from the register one position below the current MSB as it shifts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      active  <= 1'b0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
    end else if (load) begin
      shreg   <= data;
      bit_cnt <= '0;
      phase   <= 1'b0;
      active  <= 1'b1;
      sclk    <= 1'b0;
      sdata   <= data[c_bpc-1];
    end else if (active) begin
      if (!phase) begin
        phase <= 1'b1;
        sclk  <= 1'b1;
      end else if (bit_cnt == c_bit_last) begin
        phase  <= 1'b0;
        active <= 1'b0;
        sclk   <= 1'b0;
        sdata  <= 1'b0;
      end else begin
        phase   <= 1'b0;
        sclk    <= 1'b0;
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {shreg[c_bpc-2:0], 1'b0};
        sdata   <= shreg[c_bpc-2];
      end
    end
  end

  // Done marks the last cycle of the last bit so the controller can leave
  // SHIFT on exactly the same edge the serializer goes idle.
  assign done = active && phase && (bit_cnt == c_bit_last);

endmodule

// File: rtl/led_shifter.sv
// led_shifter
// Frame refresh engine sitting directly after the framebuffer. Walks every
// channel from c_channels-1 down to 0 through the framebuffer's registered
// read port, serialises each value MSB-first onto the daisy-chained LED
// drivers, pulses the driver latch, then waits the dwell time (in ticks of
// c_tick_div cycles) captured from the framebuffer time output at the latch.
//
// Ports:
//   i_clk    in   rising-edge clock
//   i_rst    in   synchronous active-high reset
//   o_raddr  out  framebuffer read address (current channel)
//   i_rdata  in   framebuffer read data, one cycle after o_raddr
//   i_time   in   dwell ticks applied after the next latch
//   o_sclk   out  driver serial clock
//   o_sdata  out  driver serial data
//   o_xlat   out  one-cycle driver latch pulse
//   o_busy   out  high from the first fetch through the latch
//   o_blank  out  blanking output, present only with LED_SHIFTER_BLANK_EN
//
// Build option: define LED_SHIFTER_BLANK_EN to add o_blank, which is high in
// reset, during GAP and LATCH and for two cycles after LATCH.
module led_shifter
  import lamp_pkg::*;
#(
  parameter int c_ledboards = c_ledboards_default,
  parameter int c_channels  = c_ledboards * c_ch_per_board,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_bpc       = c_bpc_default,
  parameter int c_max_time  = c_max_time_default,
  parameter int c_time_w    = time_width(c_max_time),
  parameter int c_tick_div  = c_tick_div_default
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic [c_addr_w-1:0] o_raddr,
  input  logic [c_bpc-1:0]    i_rdata,
  input  logic [c_time_w-1:0] i_time,
  output logic                o_sclk,
  output logic                o_sdata,
  output logic                o_xlat,
  output logic                o_busy
`ifdef LED_SHIFTER_BLANK_EN
  ,
  output logic                o_blank
`endif
);

  localparam int c_tick_w = cnt_width(c_tick_div);
  localparam logic [c_addr_w-1:0] c_addr_last = c_addr_w'(c_channels - 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(c_tick_div - 1);
  localparam logic [c_time_w-1:0] c_time_cap  = c_time_w'(c_max_time);

  led_state_t          state;
  led_state_t          next_state;
  logic [c_time_w-1:0] dwell_val;
  logic [c_time_w-1:0] dwell_cnt;
  logic [c_tick_w-1:0] tick_cnt;
  logic [c_time_w-1:0] time_sat;
  logic                dwell_done;
  logic                ser_load;
  logic                ser_done;

  // Dwell values beyond the supported maximum are clamped rather than
  // wrapped so an out-of-range request still gives the longest dwell.
  assign time_sat   = (i_time > c_time_cap) ? c_time_cap : i_time;
  assign dwell_done = (dwell_cnt == dwell_val);

  // The framebuffer registers the read in FETCH0, so its data is on i_rdata
  // during FETCH1 and is handed to the serializer then.
  assign ser_load = (state == FETCH1);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= DWELL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Channel 0 is the last channel shifted, so reaching the
  // end of its bits closes the frame through GAP and LATCH.
  always_comb begin
    next_state = state;
    case (state)
      DWELL:   if (dwell_done) next_state = FETCH0;
      FETCH0:  next_state = FETCH1;
      FETCH1:  next_state = SHIFT;
      SHIFT: begin
        if (ser_done) begin
          next_state = (o_raddr == '0) ? GAP : FETCH0;
        end
      end
      GAP:     next_state = LATCH;
      LATCH:   next_state = DWELL;
      default: next_state = DWELL;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with the
  // state they describe while still coming straight from flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_xlat <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      o_xlat <= (next_state == LATCH);
      o_busy <= (next_state != DWELL);
    end
  end

  // Address counter. The address already points at the next channel when
  // FETCH0 starts, so it steps down on the last SHIFT cycle and is reloaded
  // for the following frame as the latch completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_raddr <= c_addr_last;
    end else if (state == LATCH) begin
      o_raddr <= c_addr_last;
    end else if ((state == SHIFT) && ser_done && (o_raddr != '0)) begin
      o_raddr <= o_raddr - 1'b1;
    end
  end

  // Dwell timer. The dwell value is captured only at LATCH so a time change
  // mid-frame waits for the next latch. The exit cycle itself is where the
  // count is found equal, giving dwell*c_tick_div + 1 cycles in DWELL.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dwell_val <= '0;
      dwell_cnt <= '0;
      tick_cnt  <= '0;
    end else if (state == LATCH) begin
      dwell_val <= time_sat;
      dwell_cnt <= '0;
      tick_cnt  <= '0;
    end else if ((state == DWELL) && !dwell_done) begin
      if (tick_cnt == c_tick_last) begin
        tick_cnt  <= '0;
        dwell_cnt <= dwell_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Serial datapath: owns the shift register and the serial bus pins.
  led_serializer #(
    .c_bpc (c_bpc)
  ) u_serializer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .load  (ser_load),
    .data  (i_rdata),
    .done  (ser_done),
    .sclk  (o_sclk),
    .sdata (o_sdata)
  );

`ifdef LED_SHIFTER_BLANK_EN
  logic blank_tail;

  // Blanking covers GAP and LATCH plus two cycles after the latch: the first
  // comes from seeing LATCH as the current state, the second from a one-cycle
  // delayed copy of that.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_blank    <= 1'b1;
      blank_tail <= 1'b0;
    end else begin
      blank_tail <= (state == LATCH);
      o_blank    <= (next_state == GAP) || (next_state == LATCH) ||
                    (state == LATCH) || blank_tail;
    end
  end
`endif

endmodule
